// File: rtl/flag_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flag_branch_unit_pkg
// Brief    : Opcode, condition-code and flag-index constants for the flag unit.
// Revision : 1.0
// ============================================================================
package flag_branch_unit_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_RED = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1000;
    localparam logic [3:0] OP_LD  = 4'b1001;
    localparam logic [3:0] OP_ST  = 4'b1010;
    localparam logic [3:0] OP_BR  = 4'b1011;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;
    localparam logic [3:0] OP_NOP = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fbu_state_t;

    function automatic logic writes_zvn(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic writes_z_only(input logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_branch_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Brief    : Combinational branch-condition evaluation on a {Z,V,N} vector.
// Revision : 1.0
// ============================================================================
module cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE: taken = !w_z;
            COND_EQ: taken = w_z;
            COND_GT: taken = !w_z && !w_n;
            COND_LT: taken = w_n;
            COND_GE: taken = w_z || (!w_z && !w_n);
            COND_LE: taken = w_n || w_z;
            COND_OV: taken = w_v;
            default: taken = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_branch_unit
// Brief    : Z/V/N flag register, branch resolution with dependency stall or
//            forwarding (FLAG_FWD_EN), and saturating branch statistics.
// Revision : 1.0
// ============================================================================
module flag_branch_unit
    import flag_branch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic        ex_ovfl,
    input  logic        ex_flush,
    input  logic        pipe_stall,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    output logic [2:0]  flags,
    output logic        flag_stall,
    output logic        br_resolved,
    output logic        br_taken,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
);

    fbu_state_t  r_state;
    fbu_state_t  w_state_next;
    logic [2:0]  r_flags;
    logic [15:0] r_br_count;
    logic [15:0] r_taken_count;

    logic        w_wr_zvn;
    logic        w_wr_z;
    logic        w_pending;
    logic        w_flag_we;
    logic [2:0]  w_next_flags;
    logic        w_resolve;
    logic        w_stall;
    logic        w_use_next;
    logic [2:0]  w_eval_flags;
    logic        w_taken;

    assign w_wr_zvn  = writes_zvn(ex_opcode);
    assign w_wr_z    = writes_z_only(ex_opcode);
    assign w_pending = ex_valid && !ex_flush && (w_wr_zvn || w_wr_z);
    assign w_flag_we = w_pending && !pipe_stall;

    // Z-only writers keep V and N from the register.
    always_comb begin
        w_next_flags         = r_flags;
        w_next_flags[FLAG_Z] = (ex_result == 16'h0000);
        if (w_wr_zvn) begin
            w_next_flags[FLAG_V] = ex_ovfl;
            w_next_flags[FLAG_N] = ex_result[15];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_resolve    = 1'b0;
        w_stall      = 1'b0;
        w_use_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (br_valid) begin
                    if (!w_pending) begin
                        w_resolve = 1'b1;
                    end else begin
`ifdef FLAG_FWD_EN
                        w_resolve  = 1'b1;
                        w_use_next = 1'b1;
`else
                        w_stall      = 1'b1;
                        w_state_next = ST_WAIT;
`endif
                    end
                end
            end
            ST_WAIT: begin
                // Producer flags have landed; a dropped br_valid means ID was flushed.
                w_state_next = ST_IDLE;
                w_resolve    = br_valid;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (pipe_stall) begin
            w_resolve    = 1'b0;
            w_state_next = r_state;
        end
    end

    assign w_eval_flags = w_use_next ? w_next_flags : r_flags;

    cond_eval u_cond_eval (
        .flags (w_eval_flags),
        .cond  (br_cond),
        .taken (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_flags       <= 3'b000;
            r_br_count    <= 16'h0000;
            r_taken_count <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            if (w_flag_we) begin
                r_flags <= w_next_flags;
            end
            if (w_resolve) begin
                if (r_br_count != 16'hFFFF) begin
                    r_br_count <= r_br_count + 16'h0001;
                end
                if (w_taken && (r_taken_count != 16'hFFFF)) begin
                    r_taken_count <= r_taken_count + 16'h0001;
                end
            end
        end
    end

    assign flags       = r_flags;
    assign flag_stall  = w_stall;
    assign br_resolved = w_resolve;
    assign br_taken    = w_resolve && w_taken;
    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;

endmodule
`default_nettype wire
